// File: rtl/ibex_fetch_align_fifo.sv
// Instruction fetch FIFO with half-word aligner.
// Word-aligned fetch responses are stored in a small shift FIFO (entry 0 is the
// head). The output side presents one 16-bit or 32-bit instruction per
// handshake, stitching unaligned 32-bit instructions across two words.
module ibex_fetch_align_fifo #(
   parameter int NUM_REQS = 2,
   parameter bit RV32C    = 1'b1,
   parameter bit BYPASS   = 1'b1,
   localparam int DEPTH   = NUM_REQS + 1,
   localparam int LW      = $clog2(DEPTH + 1)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          clear_i,
   input  logic          in_valid_i,
   output logic          in_ready_o,
   input  logic [31:0]   in_addr_i,
   input  logic [31:0]   in_rdata_i,
   input  logic          in_err_i,
   output logic          out_valid_o,
   input  logic          out_ready_i,
   output logic [31:0]   out_addr_o,
   output logic [31:0]   out_rdata_o,
   output logic          out_err_o,
   output logic          out_err_plus2_o,
   output logic [LW-1:0] level_o
);

   logic [DEPTH-1:0] valid_q, valid_d, shifted, lower, wr;
   logic [31:0]      rdata_q [DEPTH];
   logic [31:0]      rdata_shift [DEPTH];
   logic [DEPTH-1:0] err_q;
   logic [31:1]      addr_q, addr_d;

   logic [31:0] head_rdata;
   logic        head_valid, head_err;
   logic [15:0] next_half;
   logic        next_valid, next_err;
   logic        unaligned, compressed, handshake, pop, push;

   // bit 0 of the restart address is meaningless for a half-word aligned PC
   logic unused_in_addr0;
   assign unused_in_addr0 = in_addr_i[0];

   // head word and the word after it, from storage or the bypass path
   always_comb begin
      head_rdata = valid_q[0] ? rdata_q[0] : in_rdata_i;
      head_valid = valid_q[0] | (BYPASS & in_valid_i);
      head_err   = valid_q[0] ? err_q[0] : (BYPASS & in_valid_i & in_err_i);
      next_half  = valid_q[1] ? rdata_q[1][15:0] : in_rdata_i[15:0];
      next_valid = valid_q[1] | (BYPASS & valid_q[0] & in_valid_i);
      next_err   = valid_q[1] ? err_q[1] : (BYPASS & valid_q[0] & in_valid_i & in_err_i);
   end

   // instruction decode: alignment, length, output valid/data/errors, pop
   always_comb begin
      unaligned = RV32C & addr_q[1];
      if (unaligned) begin
         compressed  = RV32C & (head_rdata[17:16] != 2'b11);
         out_rdata_o = {next_half, head_rdata[31:16]};
      end else begin
         compressed  = RV32C & (head_rdata[1:0] != 2'b11);
         out_rdata_o = head_rdata;
      end
      out_valid_o     = (unaligned & ~compressed) ? (head_valid & next_valid) : head_valid;
      out_err_o       = head_err | (unaligned & ~compressed & next_err);
      out_err_plus2_o = unaligned & ~compressed & next_err & ~head_err;
      handshake       = out_valid_o & out_ready_i;
      // an aligned compressed instruction leaves the upper half in the head word
      pop             = handshake & (unaligned | ~compressed);
      // a bypassed word consumed entirely in the same cycle is not stored
      push            = in_valid_i & ~(pop & ~valid_q[0]);
   end

   // shift-down on pop, then write the incoming word into the lowest free slot
   always_comb begin
      shifted = pop ? (valid_q >> 1) : valid_q;
      lower   = {shifted[DEPTH-2:0], 1'b1};
      wr      = push ? (~shifted & lower) : '0;
      valid_d = clear_i ? '0 : (shifted | wr);
      for (int i = 0; i < DEPTH - 1; i++) begin
         rdata_shift[i] = rdata_q[i+1];
      end
      rdata_shift[DEPTH-1] = rdata_q[DEPTH-1];
   end

   // next instruction address; 31-bit arithmetic wraps naturally
   always_comb begin
      addr_d = addr_q;
      if (clear_i) begin
         addr_d = in_addr_i[31:1];
      end else if (handshake) begin
         addr_d = addr_q + (compressed ? 31'd1 : 31'd2);
      end
      if (!RV32C) begin
         addr_d[1] = 1'b0;
      end
   end

   // valid bits and address register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= '0;
         addr_q  <= '0;
      end else begin
         valid_q <= valid_d;
         addr_q  <= addr_d;
      end
   end

   // data and error storage, only enabled on push or shift
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (wr[i]) begin
            rdata_q[i] <= in_rdata_i;
            err_q[i]   <= in_err_i;
         end else if (pop) begin
            rdata_q[i] <= rdata_shift[i];
            err_q[i]   <= (i < DEPTH - 1) ? err_q[(i < DEPTH - 1) ? i + 1 : i] : err_q[i];
         end
      end
   end

   // occupancy count
   always_comb begin
      level_o = '0;
      for (int i = 0; i < DEPTH; i++) begin
         level_o = level_o + LW'(valid_q[i]);
      end
   end

   assign in_ready_o = ~valid_q[DEPTH-NUM_REQS];
   assign out_addr_o = {addr_q, 1'b0};

   // the prefetcher must never deliver a response with no free slot
   always @(posedge clk_i) begin
      if (rst_ni) begin
         no_overflow: assert (!(in_valid_i && valid_q[DEPTH-1] && !clear_i));
      end
   end

endmodule
